// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Turns single CPU load/store requests into one-cycle strobes towards a
//   32-word data memory and returns a one-cycle response. One request is in
//   flight at a time; requests presented while busy are ignored, not queued.
//
//   Memory timing assumed: the memory samples mem_read_o / mem_write_o,
//   mem_address_o and mem_write_data_o on the falling clock edge and updates
//   mem_read_data_i on the falling edge as well, so read data requested in one
//   cycle is available at the next rising edge.
//
// Configuration:
//   LSU_BYTE_EN  - when defined, req_byte_i=1 selects a little-endian byte
//                  access. Byte loads use the normal read path; byte stores
//                  read-modify-write the containing word through RMW_RD.
//                  When undefined, req_byte_i is ignored and every access
//                  is a word access.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             asynchronous active-high reset
//   req_valid_i       CPU presents a request
//   req_ready_o       unit is idle and will accept a request this cycle
//   req_write_i       1 = store, 0 = load
//   req_byte_i        1 = byte access (LSU_BYTE_EN only), 0 = word access
//   req_addr_i        byte address
//   req_wdata_i       store data (byte stores use bits 7:0)
//   resp_valid_o      one-cycle completion pulse
//   resp_data_o       load result, held until the next response
//   resp_err_o        request rejected, held until the next response
//   mem_address_o     word index into the data memory, zero-extended
//   mem_write_data_o  word written to the data memory
//   mem_read_data_i   word read from the data memory
//   mem_read_o        registered read strobe
//   mem_write_o       registered write strobe
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  input  logic [31:0] mem_read_data_i,
  output logic        mem_read_o,
  output logic        mem_write_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
`ifdef LSU_BYTE_EN
    ,
    S_RMW_RD
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        byte_acc;     // request is a byte access (always 0 without LSU_BYTE_EN)
  logic        req_err;      // request is rejected without touching memory
  logic [31:0] load_result;  // value returned for a completed load

`ifdef LSU_BYTE_EN
  // Byte-access context captured at acceptance.
  logic        byte_q, byte_d;
  logic [1:0]  offset_q, offset_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic [31:0] rd_shifted;   // read word shifted so the selected lane sits in 7:0
  logic [31:0] rmw_word;     // old word with the selected lane replaced

  assign byte_acc   = req_byte_i;
  assign rd_shifted = mem_read_data_i >> {offset_q, 3'b000};

  always_comb begin
    rmw_word = mem_read_data_i;
    rmw_word[{offset_q, 3'b000} +: 8] = byte_data_q;
  end

  assign load_result = byte_q ? {24'b0, rd_shifted[7:0]} : mem_read_data_i;
`else
  logic unused_req_byte;

  assign byte_acc        = 1'b0;
  assign unused_req_byte = req_byte_i;
  assign load_result     = mem_read_data_i;
`endif

  // Addresses beyond the 32-word memory are always illegal; word accesses
  // must also be word aligned. Byte accesses may use any offset.
  assign req_err = (|req_addr_i[31:7]) || (!byte_acc && (|req_addr_i[1:0]));

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch. Strobes default to 0, which
    // keeps them low in IDLE and RESP and limits each to a single cycle.
    state_d       = state_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
`ifdef LSU_BYTE_EN
    byte_d        = byte_q;
    offset_d      = offset_q;
    byte_data_d   = byte_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_err) begin
            // Rejected: straight to the response, memory left untouched.
            state_d     = S_RESP;
            resp_err_d  = 1'b1;
            resp_data_d = 32'b0;
          end else begin
            mem_address_d = {27'b0, req_addr_i[6:2]};
`ifdef LSU_BYTE_EN
            byte_d        = byte_acc;
            offset_d      = req_addr_i[1:0];
            byte_data_d   = req_wdata_i[7:0];
`endif
            if (req_write_i) begin
              state_d     = S_WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata_i;
`ifdef LSU_BYTE_EN
              // A byte store must first fetch the word it modifies.
              if (byte_acc) begin
                state_d     = S_RMW_RD;
                mem_write_d = 1'b0;
                mem_read_d  = 1'b1;
              end
`endif
            end else begin
              state_d    = S_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end

      S_RD: begin
        state_d     = S_RESP;
        resp_err_d  = 1'b0;
        resp_data_d = load_result;
      end

`ifdef LSU_BYTE_EN
      S_RMW_RD: begin
        state_d     = S_WR;
        mem_write_d = 1'b1;
        mem_wdata_d = rmw_word;
      end
`endif

      S_WR: begin
        state_d     = S_RESP;
        resp_err_d  = 1'b0;
        resp_data_d = 32'b0;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above regardless of
  // statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'b0;
      mem_wdata_q   <= 32'b0;
      resp_data_q   <= 32'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
    end
  end

`ifdef LSU_BYTE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_q      <= 1'b0;
      offset_q    <= 2'b00;
      byte_data_q <= 8'h00;
    end else begin
      byte_q      <= byte_d;
      offset_q    <= offset_d;
      byte_data_q <= byte_data_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready_o      = (state_q == S_IDLE);
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_data_o      = resp_data_q;
  assign resp_err_o       = resp_err_q;
  assign mem_address_o    = mem_address_q;
  assign mem_write_data_o = mem_wdata_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit with directed and random requests. A negedge-driven
// 32-word memory sits behind the DUT; a separate reference array holds the
// memory contents the requests should produce, and every response, strobe
// count, latency and written word is compared against values derived from
// that array and the request itself.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read;
  logic        mem_write;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem     [32];  // memory seen by the DUT
  logic [31:0] ref_mem [32];  // contents the requests should produce
  logic        preload;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_byte_i       (req_byte),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .resp_err_o       (resp_err),
    .mem_address_o    (mem_address),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data),
    .mem_read_o       (mem_read),
    .mem_write_o      (mem_write)
  );

  // Data memory: strobes sampled and read data updated on the falling edge.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      mem[mem_address[4:0]] <= mem_write_data;
    end
    mem_read_data <= mem[mem_address[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request end to end: expectations come from the address rules and the
  // reference array, then the DUT is observed cycle by cycle after acceptance.
  task automatic run_req(input logic w, input logic b, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic        byte_eff;
    logic        err;
    logic [4:0]  idx;
    int          off;
    logic [31:0] exp_data;
    logic [31:0] exp_word;
    int          exp_rd, exp_wr, exp_lat;
    int          rd_cnt, wr_cnt, lat;
    logic        seen;

`ifdef LSU_BYTE_EN
    byte_eff = b;
`else
    byte_eff = 1'b0;
`endif
    err = (addr > 32'd127) || (!byte_eff && (addr % 4 != 0));
    idx = addr[6:2];
    off = int'(addr % 4);

    exp_data = 32'b0;
    exp_word = ref_mem[idx];
    if (!err && !w) begin
      if (byte_eff) exp_data = (ref_mem[idx] / (32'd1 << (8 * off))) % 256;
      else          exp_data = ref_mem[idx];
    end
    if (!err && w) begin
      if (byte_eff) begin
        exp_word = ref_mem[idx] - (((ref_mem[idx] / (32'd1 << (8 * off))) % 256) << (8 * off))
                   + ((wdata % 256) << (8 * off));
      end else begin
        exp_word = wdata;
      end
    end
    exp_rd  = (!err && (!w || byte_eff)) ? 1 : 0;
    exp_wr  = (!err && w) ? 1 : 0;
    exp_lat = err ? 0 : ((w && byte_eff) ? 2 : 1);

    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_addr  = addr;
    req_wdata = wdata;

    @(posedge clk);
    #1;
    // Keep presenting junk while busy; it must be ignored.
    req_write = 1'($urandom_range(0, 1));
    req_byte  = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;

    rd_cnt = 0;
    wr_cnt = 0;
    lat    = -1;
    seen   = 1'b0;
    for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
      if (mem_read && mem_write) check("strobe_overlap", 32'd1, 32'd0);
      if (mem_read) begin
        rd_cnt++;
        check("rd_address", mem_address, {27'b0, idx});
      end
      if (mem_write) begin
        wr_cnt++;
        check("wr_address", mem_address, {27'b0, idx});
        check("wr_data", mem_write_data, exp_word);
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat  = cyc;
        req_valid = 1'b0;
        check("resp_err", {31'b0, resp_err}, {31'b0, err});
        if (err || !w) check("resp_data", resp_data, exp_data);
      end else begin
        check("ready_busy", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    check("resp_seen", {31'b0, seen}, 32'd1);
    check("latency", lat, exp_lat);
    check("rd_pulses", rd_cnt, exp_rd);
    check("wr_pulses", wr_cnt, exp_wr);

    // Response values persist after the pulse.
    @(posedge clk);
    #1;
    check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    check("hold_err", {31'b0, resp_err}, {31'b0, err});
    if (err || !w) check("hold_data", resp_data, exp_data);

    if (!err && w) begin
      ref_mem[idx] = exp_word;
      check("mem_word", mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    preload   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'b0;
    req_wdata = 32'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[7] = 32'd666;
    ref_mem[9] = 32'h1122_3344;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    preload = 1'b0;
    rst     = 1'b0;

    // Directed cases.
    run_req(1'b0, 1'b0, 32'h1C, 32'h0);            // word 7 load -> 666
    run_req(1'b1, 1'b0, 32'h24, 32'h1234_5678);    // store word 9
    run_req(1'b0, 1'b0, 32'h24, 32'h0);            // load it back
    run_req(1'b0, 1'b0, 32'h80, 32'h0);            // out of range
    run_req(1'b0, 1'b0, 32'h06, 32'h0);            // misaligned word
    run_req(1'b1, 1'b0, 32'h7C, 32'hDEAD_BEEF);    // top word
    run_req(1'b0, 1'b0, 32'h7C, 32'h0);
`ifdef LSU_BYTE_EN
    run_req(1'b1, 1'b0, 32'h24, 32'h1122_3344);
    run_req(1'b1, 1'b1, 32'h26, 32'h0000_00AA);    // -> 0x11AA3344
    check("byte_store_word9", mem[9], 32'h11AA_3344);
    run_req(1'b0, 1'b1, 32'h26, 32'h0);            // -> 0xAA
    run_req(1'b0, 1'b1, 32'h7F, 32'h0);            // top byte of last word
    run_req(1'b0, 1'b1, 32'h81, 32'h0);            // byte out of range
`endif

    // Reset in the middle of a read.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h1C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_rd_strobe", {31'b0, mem_read}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_strobe", {31'b0, mem_read}, 32'd0);
    check("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    end

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else                           a = 32'($urandom_range(0, 127));
      run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 ReqValid  input  1  CPU presents a load/store request.
REQ-004 ReqReady  output  1  unit can accept a request this cycle.
REQ-005 ReqWrite  input  1  1 = store, 0 = load.
REQ-006 ReqByte  input  1  1 = byte access (honoured only under LSU_BYTE_EN), 0 = word access.
REQ-007 ReqAddr  input  32  byte address.
REQ-008 ReqWData  input  32  store data; byte stores use bits 7:0.
REQ-009 RespValid  output  1  one-cycle pulse; request completed.
REQ-010 RespData  output  32  load result; valid while RespValid=1.
REQ-011 RespErr  output  1  request rejected; valid while RespValid=1.
REQ-012 MemAddress  output  32  word index to data memory, zero-extended.
REQ-013 MemWriteData  output  32  word to data memory.
REQ-014 MemReadData  input  32  word from data memory; memory updates it on negedge Clk.
REQ-015 MemRead / MemWrite  output  1 each  memory strobes; the memory samples them on negedge Clk.

Function
REQ-016 FSM states SHALL be IDLE, RD, WR, RESP; LSU_BYTE_EN adds RMW_RD.
REQ-017 ReqReady SHALL be 1 only in IDLE; a request is accepted at a posedge with ReqValid=1 and ReqReady=1; address, data, ReqWrite and ReqByte are latched at that edge.
REQ-018 Word index SHALL be ReqAddr[6:2] (32-word memory); MemAddress = {27'b0, index}.
REQ-019 Error conditions: ReqAddr[31:7] != 0, or word access with ReqAddr[1:0] != 0.
REQ-020 On an error request: IDLE->RESP; no memory strobe asserted; RespErr=1; RespData=0.
REQ-021 Word load: IDLE->RD; MemRead=1 for exactly one cycle; at the next posedge RespData <= MemReadData and RD->RESP.
REQ-022 Word store: IDLE->WR; MemWrite=1 and MemWriteData=latched data for exactly one cycle; WR->RESP.
REQ-023 RESP SHALL last one cycle with RespValid=1, then return to IDLE.
REQ-024 Latency: RespValid is high in the second cycle after acceptance (accept edge T0, response during T1..T2); ReqReady is low from T0 until RESP exits.
REQ-025 MemRead and MemWrite SHALL be registered, SHALL never both be 1, and SHALL be 0 in IDLE and RESP.
REQ-026 RespData and RespErr SHALL hold their values until the next response and SHALL be 0 after reset.
REQ-027 ReqValid in any non-IDLE state SHALL be ignored; requests are not queued.

Reset
REQ-028 Reset SHALL force IDLE and set ReqReady=1, RespValid=0, RespErr=0, RespData=0, MemAddress=0, MemWriteData=0, MemRead=0, MemWrite=0.
REQ-029 Reset asserted mid-operation SHALL drop the strobes immediately and abort the request without a response.

Configuration
REQ-030 Macro LSU_BYTE_EN defined: ReqByte=1 accesses a byte (little-endian; ReqAddr[1:0]=0 selects bits 7:0); any byte offset is legal.
REQ-031 With LSU_BYTE_EN, byte load uses the RD path; RespData = selected byte zero-extended.
REQ-032 With LSU_BYTE_EN, byte store runs IDLE->RMW_RD (MemRead for one cycle)->WR (MemWrite with the old word, selected lane replaced by ReqWData[7:0])->RESP; RespValid is high during T2..T3.
REQ-033 Without LSU_BYTE_EN: ReqByte is ignored, all accesses are word accesses, and there is no RMW_RD state.

Verification
REQ-034 Memory word 7 = 666; load ReqAddr=0x1C -> MemRead pulse, MemAddress=7; RespValid 2 cycles after accept, RespData=666, RespErr=0.
REQ-035 Store 0x12345678 to ReqAddr=0x24, then load 0x24 -> one MemWrite pulse at MemAddress=9; the load returns 0x12345678.
REQ-036 Load ReqAddr=0x80 and load ReqAddr=0x06 -> RespErr=1, RespData=0, no MemRead/MemWrite pulse.
REQ-037 Reset asserted during the RD cycle -> MemRead falls immediately, no RespValid, ReqReady=1 after release.
REQ-038 LSU_BYTE_EN: word 9 = 0x11223344; byte store 0xAA to ReqAddr=0x26 -> word 9 = 0x11AA3344; byte load 0x26 -> RespData=0x000000AA.
